// File: rtl/logic16_arbiter.sv
// logic16_arbiter: two requesters share one WIDTH-bit bitwise logic unit
// (AND / OR / XOR / NOT a). IDLE -> EXEC -> DONE handshake, one operation
// every two cycles when requests are held.
// Optional build macro: LOGIC16_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin between simultaneous requesters
//   undefined -> fixed priority, requester 0 always wins
// Outputs are all registered. An asynchronous active-low reset aborts any
// in-flight operation, and no done is ever produced for it.

// One bit of the shared logic unit; opcode is common to every slice.
module logic16_bitslice (
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       r
);
    // per-bit logic function, no carries between slices
    always_comb begin
        r = 1'b0;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~a;
        endcase
    end
endmodule

module logic16_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    // captured request: operands and the id of the requester that owns them
    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             id;
    } req_t;

    state_t           state;
    req_t             cap;
    req_t             win;
    logic             pick1;
    logic             any_req;
    logic             can_arb;
    logic [WIDTH-1:0] unit_r;

    assign any_req = req0 | req1;
    // arbitration is only open outside EXEC; requests seen in EXEC are ignored
    assign can_arb = (state != EXEC);

`ifdef LOGIC16_ARB_ROUND_ROBIN_EN
    // id of the last granted requester; reset to 1 so requester 0 goes first
    logic last_id;

    // on a tie the requester not granted last wins
    always_comb begin
        pick1 = req1 & (~req0 | ~last_id);
    end

    // pointer follows every grant
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            last_id <= 1'b1;
        else if (can_arb && any_req)
            last_id <= pick1;
    end
`else
    // fixed priority: requester 1 wins only when requester 0 is quiet
    always_comb begin
        pick1 = req1 & ~req0;
    end
`endif

    // mux the winning requester's operands into a capture record
    always_comb begin
        win = '0;
        if (pick1) begin
            win.op = op1;
            win.a  = a1;
            win.b  = b1;
            win.id = 1'b1;
        end else begin
            win.op = op0;
            win.a  = a0;
            win.b  = b0;
            win.id = 1'b0;
        end
    end

    // the single shared logic unit, built from WIDTH identical bit slices
    // and fed only from the captured record
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic16_bitslice u_slice (
            .op (cap.op),
            .a  (cap.a[i]),
            .b  (cap.b[i]),
            .r  (unit_r[i])
        );
    end

    // control FSM with registered grant / busy / done / result outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cap     <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (any_req) begin
                        cap   <= win;
                        gnt0  <= ~pick1;
                        gnt1  <= pick1;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    result  <= unit_r;
                    done_id <= cap.id;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset)
        !(gnt0 && gnt1));
    a_exec_one_cycle: assert property (@(posedge clock) disable iff (!reset)
        busy |=> (done && !busy));
`endif

endmodule

// File: tb/tb_logic16_arbiter.sv
// Bench for logic16_arbiter: reset values, a vector table of single
// operations, hand sequences (held requests, abort in EXEC, operand change
// in EXEC) and a random phase checked against a transaction-level model.
module tb_logic16_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  op0 = '0, op1 = '0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, done, done_id, busy;
    logic [15:0] result;

    int total = 0;
    int bad   = 0;

    logic16_arbiter #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done(done), .done_id(done_id),
        .result(result), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    op_t         q[$];
    int          m_age;      // cycles since the last grant edge
    logic        m_last;     // last granted requester
    logic        m_gnt0, m_gnt1, m_busy, m_done, m_done_id;
    logic [15:0] m_result;

    function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic winner(input logic r0, input logic r1, input logic last);
`ifdef LOGIC16_ARB_ROUND_ROBIN_EN
        if (r0 && r1) return ~last;
`endif
        return r0 ? 1'b0 : 1'b1;
    endfunction

    task automatic model_clear();
        q.delete();
        m_age = 100; m_last = 1'b1;
        m_gnt0 = 0; m_gnt1 = 0; m_busy = 0; m_done = 0; m_done_id = 0;
        m_result = '0;
    endtask

    // advance the model across one rising edge using the present inputs
    task automatic model_edge();
        bit   open;
        op_t  e;
        logic w;
        open = (m_age != 1);  // the cycle right after a grant is execution
        if (m_age < 100) m_age++;
        if (open && (req0 || req1)) begin
            w = winner(req0, req1, m_last);
            e.id = w;
            e.op = w ? op1 : op0;
            e.a  = w ? a1 : a0;
            e.b  = w ? b1 : b0;
            q.push_back(e);
            m_last = w;
            m_age  = 1;
        end
        m_gnt0 = (m_age == 1) && !m_last;
        m_gnt1 = (m_age == 1) && m_last;
        m_busy = (m_age == 1);
        m_done = (m_age == 2);
        if (m_done && q.size() > 0) begin
            e = q.pop_front();
            m_result  = ref_op(e.op, e.a, e.b);
            m_done_id = e.id;
        end
    endtask

    // one clock: model update, edge, compare everything against the model
    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        chk("model", {11'd0, gnt0, gnt1, busy, done, done_id, result},
                     {11'd0, m_gnt0, m_gnt1, m_busy, m_done, m_done_id, m_result});
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {11'd0, gnt0, gnt1, busy, done, done_id, result}, 32'd0);
    endtask

    // assert reset now (off-edge), check outputs clear at once, release after next edge
    task automatic do_reset(input string nm);
        reset = 1'b0;
        #1;
        chk_zero(nm);
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b0, 2'd1, 16'h00F0, 16'h0F00, 16'h0FF0};
        vt[1] = '{1'b1, 2'd0, 16'hAAAA, 16'hFFFF, 16'hAAAA};
        vt[2] = '{1'b1, 2'd1, 16'hAAAA, 16'hFFFF, 16'hFFFF};
        vt[3] = '{1'b1, 2'd2, 16'hAAAA, 16'hFFFF, 16'h5555};
        vt[4] = '{1'b1, 2'd3, 16'hAAAA, 16'hFFFF, 16'h5555};
        vt[5] = '{1'b0, 2'd0, 16'h1234, 16'hFF00, 16'h1200};
        vt[6] = '{1'b0, 2'd2, 16'hFFFF, 16'h0000, 16'hFFFF};
        vt[7] = '{1'b0, 2'd3, 16'h0000, 16'h1234, 16'hFFFF};

        model_clear();
        // reset state, sampled after a clock edge with reset still low
        @(posedge clock);
        #1;
        chk_zero("reset_state");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // single operations from the vector table; first one lands on the
        // first edge after reset release
        foreach (vt[i]) begin
            if (vt[i].id) begin req1 = 1; op1 = vt[i].op; a1 = vt[i].a; b1 = vt[i].b; end
            else          begin req0 = 1; op0 = vt[i].op; a0 = vt[i].a; b0 = vt[i].b; end
            step();
            chk("vec_gnt", {30'd0, gnt1, gnt0}, vt[i].id ? 32'd2 : 32'd1);
            chk("vec_busy", {31'd0, busy}, 32'd1);
            req0 = 0; req1 = 0;
            step();
            chk("vec_done", {31'd0, done}, 32'd1);
            chk("vec_id", {31'd0, done_id}, {31'd0, vt[i].id});
            chk("vec_result", {16'd0, result}, {16'd0, vt[i].exp});
            step();
            chk("vec_hold", {15'd0, done, result}, {15'd0, 1'b0, vt[i].exp});
        end

        // both requesters held: grant order and one done every two cycles
        do_reset("reset_b2b");
        req0 = 1; op0 = 2'd0; a0 = 16'hFF00; b0 = 16'h0FF0;
        req1 = 1; op1 = 2'd1; a1 = 16'h000F; b1 = 16'h00F0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("b2b_done", {31'd0, done}, {31'd0, 1'(i % 2)});
            if (i % 2 == 0) begin
`ifdef LOGIC16_ARB_ROUND_ROBIN_EN
                chk("b2b_order", {30'd0, gnt1, gnt0}, ((i / 2) % 2) ? 32'd2 : 32'd1);
`else
                chk("b2b_order", {30'd0, gnt1, gnt0}, 32'd1);
`endif
            end
        end
        req0 = 0; req1 = 0;
        step();
        step();

        // reset asserted during EXEC aborts the operation
        req0 = 1; op0 = 2'd1; a0 = 16'h1111; b0 = 16'h2222;
        step();
        chk("abort_busy", {31'd0, busy}, 32'd1);
        req0 = 0;
        #2;
        do_reset("abort_zero");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end

        // operands changed during EXEC do not affect the result
        req0 = 1; op0 = 2'd0; a0 = 16'h1234; b0 = 16'hFF00;
        step();
        a0 = 16'h0000; b0 = 16'h0000; op0 = 2'd1; req0 = 0;
        step();
        chk("captured_ops", {16'd0, result}, 32'h0000_1200);
        step();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            op0  = 2'($urandom_range(0, 3));
            op1  = 2'($urandom_range(0, 3));
            a0   = 16'($urandom); b0 = 16'($urandom);
            a1   = 16'($urandom); b1 = 16'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
